cp0_timer: RTL and testbench
============================

# cp0_timer

Parametrised coprocessor-0 for the pipelined MIPS core, successor to the fixed six-line CP0. It holds SR, Cause, EPC and EBase, and adds a Count/Compare timer with a prescaler. It also adds two software-interrupt bits and a configurable number of hardware interrupt lines. It sits beside the M stage: it takes mtc0 writes and exception/interrupt sources, raises `req` to flush the pipeline, and supplies `epc_out` (eret target) and `ebase_out` (handler base).

## Interface
- HW_INT_N, 6: hardware interrupt lines, 1..6, mapped to Cause.IP[2 +: HW_INT_N].
- TIMER_LINE, HW_INT_N-1: hw line index the timer interrupt is ORed onto; must be < HW_INT_N.
- COUNT_DIV, 1: Count increments once every COUNT_DIV cycles; 1..256.
- EBASE_RESET, 32'h4180: EBase reset value.

Ports (clock and reset first):
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- en  in  1  mtc0 write enable.
- cp0_adr  in  5  register number: 9 Count, 11 Compare, 12 SR, 13 Cause, 14 EPC, 15 EBase.
- cp0_wd  in  32  mtc0 write data.
- vpc  in  32  PC of the victim instruction.
- bd_in  in  1  victim is in a branch delay slot.
- exc_code  in  5  internal exception code; 0 means none.
- exl_clr  in  1  eret is committing.
- hw_int  in  HW_INT_N  level interrupt lines.
- cp0_rd  out  32  mfc0 read data.
- epc_out  out  32  EPC, with a same-cycle mtc0 bypass.
- ebase_out  out  32  EBase, with a same-cycle mtc0 bypass.
- req  out  1  take exception/interrupt this cycle.
- timer_irq  out  1  Cause.TI.

## Operation
**Field layout**
- SR: IM = SR[15:8], EXL = SR[1], IE = SR[0]. Other bits always read 0, and writes to them are dropped.
- Cause: BD = [31], TI = [30], IP = [15:8], ExcCode = [6:2]. All other bits read 0.
- IP[1:0] are the software bits; they are the only Cause bits mtc0 can write.

**Pending vector**
- IP[2+i] is registered hw_int[i] each cycle. IP[2+TIMER_LINE] additionally ORs TI.
- IP bits above 2+HW_INT_N-1 read 0.

**Request generation (combinational)**
- live[7:0] = {unused 0s, hw_int with TI ORed into TIMER_LINE, IP[1:0]}.
- exter = |(live & IM) & IE.
- inter = (exc_code != 0).
- req = (inter | exter) & !EXL.

**Edge priority for SR/Cause/EPC/EBase:** reset > exl_clr > req > en.
- exl_clr: EXL <= 0. A simultaneous req is ignored.
- req:
  - BD <= bd_in.
  - EPC <= bd_in ? vpc-4 : vpc.
  - ExcCode <= exter ? 0 : exc_code. Interrupt wins over exception.
  - EXL <= 1.
  - Any same-cycle mtc0, including Count/Compare, is dropped.
- en: write the register addressed by cp0_adr. Unmapped addresses are ignored.

**Timer**
- An internal prescaler counts 0..COUNT_DIV-1; a tick occurs on its wrap.
- Each tick: Count <= Count+1. Count wraps from 32'hFFFFFFFF to 0.
- Match: TI <= 1 on the edge after Count == Compare is first true (registered compare).
- TI stays set until an mtc0 to Compare.
- mtc0 Compare: load Compare, TI <= 0. This overrides a same-cycle match.
- mtc0 Count: load Count, prescaler <= 0. This overrides a same-cycle tick.
- The timer keeps counting while EXL = 1.

**Reads and bypass**
- cp0_rd: mux of Count/Compare/SR/Cause/EPC/EBase; 0 for other addresses.
- EPC and EBase reads return cp0_wd when en is high and cp0_adr matches.
- epc_out and ebase_out use the same bypass.

## Timing
**Reset values (synchronous):**
- SR = 0, Cause = 0, EPC = 0.
- EBase = EBASE_RESET.
- Count = 0, Compare = 32'hFFFFFFFF, prescaler = 0.
- Outputs after reset: timer_irq = 0; req = (exc_code != 0), because EXL is cleared.

**Latencies**
- hw_int → req: 0 cycles, because live includes the raw line.
- hw_int → IP visible via mfc0: 1 cycle.
- Count == Compare → timer_irq: 1 cycle.
- timer_irq → req: 0 cycles, if IM/IE allow.

**State effects**
- req → EXL set: next edge. req is held low from then on until exl_clr.
- Reset mid-operation clears everything on that edge, including a pending TI and the prescaler.

## Test plan
- Reset, then mtc0 SR = 32'h0000_FC01, hw_int[2] = 1 → req = 1 in the same cycle; next edge EXL = 1, ExcCode = 0, EPC = vpc, Cause.IP[4] = 1.
- exc_code = 5'd4, bd_in = 1, vpc = 32'h3010 → EPC = 32'h300C, BD = 1, ExcCode = 4; a simultaneous mtc0 EPC is dropped.
- COUNT_DIV = 4, Compare = 10 → Count reaches 10 after 40 cycles and timer_irq rises one cycle later. mtc0 Compare = 20 clears it. Count = 32'hFFFFFFFF wraps to 0 on the next tick.
- mtc0 Cause = 32'hFFFF_FFFF with IM[0] = 1, IE = 1 → only IP[1:0] become 1; req from the software interrupt next cycle; mfc0 Cause = 32'h0000_0300.
- exl_clr and req in the same cycle → EXL = 0, EPC unchanged. mtc0 EPC = 32'h5000 → epc_out = 32'h5000 in the same cycle.
- Assert reset while TI = 1 and EXL = 1 → all registers return to their reset values; timer_irq = 0 next cycle.

Source files
------------

// File: rtl/cp0_timer.sv
// cp0_timer: coprocessor 0 for the pipelined MIPS core.
// Holds SR, Cause, EPC and EBase, plus a prescaled Count/Compare timer,
// two software interrupt bits and HW_INT_N hardware interrupt lines.
//
// Ports:
//   clk, reset   single clock, synchronous active-high reset
//   en           mtc0 write enable
//   cp0_adr      register number (9 Count, 11 Compare, 12 SR, 13 Cause,
//                14 EPC, 15 EBase)
//   cp0_wd       mtc0 write data
//   vpc, bd_in   victim PC and branch-delay-slot flag
//   exc_code     internal exception code, 0 = none
//   exl_clr      eret committing
//   hw_int       level-sensitive hardware interrupt lines
//   cp0_rd       mfc0 read data
//   epc_out      EPC with same-cycle mtc0 bypass (eret target)
//   ebase_out    EBase with same-cycle mtc0 bypass (handler base)
//   req          take exception/interrupt this cycle
//   timer_irq    Cause.TI
module cp0_timer #(
  parameter int unsigned HW_INT_N    = 6,
  parameter int unsigned TIMER_LINE  = HW_INT_N - 1,
  parameter int unsigned COUNT_DIV   = 1,
  parameter logic [31:0] EBASE_RESET = 32'h4180
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [4:0]          cp0_adr,
  input  logic [31:0]         cp0_wd,
  input  logic [31:0]         vpc,
  input  logic                bd_in,
  input  logic [4:0]          exc_code,
  input  logic                exl_clr,
  input  logic [HW_INT_N-1:0] hw_int,
  output logic [31:0]         cp0_rd,
  output logic [31:0]         epc_out,
  output logic [31:0]         ebase_out,
  output logic                req,
  output logic                timer_irq
);

  localparam logic [4:0] ADR_COUNT   = 5'd9;
  localparam logic [4:0] ADR_COMPARE = 5'd11;
  localparam logic [4:0] ADR_SR      = 5'd12;
  localparam logic [4:0] ADR_CAUSE   = 5'd13;
  localparam logic [4:0] ADR_EPC     = 5'd14;
  localparam logic [4:0] ADR_EBASE   = 5'd15;

  localparam int unsigned PW      = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(COUNT_DIV - 1);

  // SR fields
  logic [7:0]          im;
  logic                exl;
  logic                ie;
  // Cause fields
  logic                bd;
  logic                ti;
  logic [HW_INT_N-1:0] ip_hw;
  logic [1:0]          ip_sw;
  logic [4:0]          exc_r;
  // Other registers
  logic [31:0]         epc;
  logic [31:0]         ebase;
  logic [31:0]         count;
  logic [31:0]         compare;
  logic [PW-1:0]       presc;

  logic [7:0]          live;
  logic [7:0]          ip8;
  logic                exter;
  logic                inter;
  logic                wr;
  logic                tick;
  logic                match;

  // Pending vectors: live uses the raw lines (zero-latency request),
  // ip8 is the registered view returned by mfc0 Cause.
  always_comb begin
    live                  = '0;
    live[1:0]             = ip_sw;
    live[2 +: HW_INT_N]   = hw_int;
    live[2 + TIMER_LINE]  = live[2 + TIMER_LINE] | ti;
    ip8                   = '0;
    ip8[1:0]              = ip_sw;
    ip8[2 +: HW_INT_N]    = ip_hw;
    ip8[2 + TIMER_LINE]   = ip8[2 + TIMER_LINE] | ti;
  end

  assign exter = (|(live & im)) & ie;
  assign inter = (exc_code != 5'd0);
  assign req   = (inter | exter) & ~exl;

  // mtc0 is dropped whenever eret or an exception owns this edge.
  assign wr    = en & ~exl_clr & ~req;
  assign tick  = (presc == PS_LAST);
  assign match = (count == compare);

  always_ff @(posedge clk) begin
    if (reset) begin
      im      <= '0;
      exl     <= 1'b0;
      ie      <= 1'b0;
      bd      <= 1'b0;
      ti      <= 1'b0;
      ip_hw   <= '0;
      ip_sw   <= '0;
      exc_r   <= '0;
      epc     <= '0;
      ebase   <= EBASE_RESET;
      count   <= '0;
      compare <= '1;
      presc   <= '0;
    end else begin
      ip_hw <= hw_int;

      if (wr && cp0_adr == ADR_COUNT) begin
        count <= cp0_wd;
        presc <= '0;
      end else if (tick) begin
        count <= count + 32'd1;
        presc <= '0;
      end else begin
        presc <= presc + PW'(1);
      end

      if (wr && cp0_adr == ADR_COMPARE) begin
        compare <= cp0_wd;
        ti      <= 1'b0;
      end else if (match) begin
        ti <= 1'b1;
      end

      if (exl_clr) begin
        exl <= 1'b0;
      end else if (req) begin
        bd    <= bd_in;
        epc   <= bd_in ? vpc - 32'd4 : vpc;
        exc_r <= exter ? 5'd0 : exc_code;
        exl   <= 1'b1;
      end else if (en) begin
        case (cp0_adr)
          ADR_SR: begin
            im  <= cp0_wd[15:8];
            exl <= cp0_wd[1];
            ie  <= cp0_wd[0];
          end
          ADR_CAUSE: ip_sw <= cp0_wd[9:8];
          ADR_EPC:   epc   <= cp0_wd;
          ADR_EBASE: ebase <= cp0_wd;
          default:   ;
        endcase
      end
    end
  end

  assign epc_out   = (en && cp0_adr == ADR_EPC)   ? cp0_wd : epc;
  assign ebase_out = (en && cp0_adr == ADR_EBASE) ? cp0_wd : ebase;
  assign timer_irq = ti;

  always_comb begin
    cp0_rd = '0;
    case (cp0_adr)
      ADR_COUNT:   cp0_rd = count;
      ADR_COMPARE: cp0_rd = compare;
      ADR_SR:      cp0_rd = {16'b0, im, 6'b0, exl, ie};
      ADR_CAUSE:   cp0_rd = {bd, ti, 14'b0, ip8, 1'b0, exc_r, 2'b0};
      ADR_EPC:     cp0_rd = epc_out;
      ADR_EBASE:   cp0_rd = ebase_out;
      default:     cp0_rd = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_timer.sv
// Scoreboard bench for cp0_timer (HW_INT_N=6, TIMER_LINE=5, COUNT_DIV=4).
module tb_cp0_timer;

  localparam int K_RD    = 0;
  localparam int K_REQ   = 1;
  localparam int K_EPC   = 2;
  localparam int K_EBASE = 3;
  localparam int K_TI    = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [4:0]  cp0_adr;
  logic [31:0] cp0_wd;
  logic [31:0] vpc;
  logic        bd_in;
  logic [4:0]  exc_code;
  logic        exl_clr;
  logic [5:0]  hw_int;
  logic [31:0] cp0_rd;
  logic [31:0] epc_out;
  logic [31:0] ebase_out;
  logic        req;
  logic        timer_irq;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  cp0_timer #(.HW_INT_N(6), .TIMER_LINE(5), .COUNT_DIV(4), .EBASE_RESET(32'h4180)) dut (
    .clk(clk), .reset(reset), .en(en), .cp0_adr(cp0_adr), .cp0_wd(cp0_wd),
    .vpc(vpc), .bd_in(bd_in), .exc_code(exc_code), .exl_clr(exl_clr),
    .hw_int(hw_int), .cp0_rd(cp0_rd), .epc_out(epc_out), .ebase_out(ebase_out),
    .req(req), .timer_irq(timer_irq)
  );

  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input int kind, input string tag, input logic [31:0] v);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] got;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        K_RD:    got = cp0_rd;
        K_REQ:   got = {31'b0, req};
        K_EPC:   got = epc_out;
        K_EBASE: got = ebase_out;
        default: got = {31'b0, timer_irq};
      endcase
      chk(e.tag, got, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] adr, input logic [31:0] v, input string tag);
    en      = 1'b0;
    cp0_adr = adr;
    push(K_RD, tag, v);
    drain();
  endtask

  task automatic mtc0(input logic [4:0] adr, input logic [31:0] d);
    en      = 1'b1;
    cp0_adr = adr;
    cp0_wd  = d;
    tick();
    en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; cp0_adr = '0; cp0_wd = '0; vpc = '0;
    bd_in = 1'b0; exc_code = '0; exl_clr = 1'b0; hw_int = '0;
    tick(); tick();

    // Reset state
    rd(5'd9,  32'h0,        "rst_count");
    rd(5'd11, 32'hFFFFFFFF, "rst_compare");
    rd(5'd12, 32'h0,        "rst_sr");
    rd(5'd13, 32'h0,        "rst_cause");
    rd(5'd14, 32'h0,        "rst_epc");
    rd(5'd15, 32'h4180,     "rst_ebase");
    rd(5'd10, 32'h0,        "rd_unmapped");
    push(K_TI,  "rst_ti",  32'd0);
    push(K_REQ, "rst_req", 32'd0);
    drain();
    exc_code = 5'd3;
    push(K_REQ, "rst_req_exc", 32'd1);
    drain();
    exc_code = 5'd0;
    reset = 1'b0;
    tick();

    // Hardware interrupt: same-cycle req, registered IP
    mtc0(5'd12, 32'h0000FC01);
    hw_int = 6'b000100; vpc = 32'h1000;
    push(K_REQ, "hw_req", 32'd1);
    drain();
    tick();
    rd(5'd12, 32'h0000FC03, "t1_sr");
    rd(5'd13, 32'h00001000, "t1_cause");
    rd(5'd14, 32'h00001000, "t1_epc");
    push(K_REQ, "t1_req_held", 32'd0);
    drain();
    hw_int = '0;
    exl_clr = 1'b1;
    tick();
    exl_clr = 1'b0;
    rd(5'd12, 32'h0000FC01, "t1_exl_clr");

    // Exception in delay slot; simultaneous mtc0 EPC dropped
    exc_code = 5'd4; bd_in = 1'b1; vpc = 32'h3010;
    en = 1'b1; cp0_adr = 5'd14; cp0_wd = 32'hDEADBEEF;
    push(K_REQ, "t2_req", 32'd1);
    drain();
    tick();
    en = 1'b0; exc_code = 5'd0; bd_in = 1'b0;
    rd(5'd14, 32'h0000300C, "t2_epc");
    rd(5'd13, 32'h80000010, "t2_cause");
    push(K_EPC, "t2_epc_out", 32'h0000300C);
    drain();

    // exl_clr beats a simultaneous req; EPC/EBase bypass
    exl_clr = 1'b1;
    tick();
    exl_clr = 1'b1; exc_code = 5'd7; vpc = 32'h7000;
    push(K_REQ, "t5_req", 32'd1);
    drain();
    tick();
    exl_clr = 1'b0; exc_code = 5'd0;
    rd(5'd12, 32'h0000FC01, "t5_sr");
    rd(5'd14, 32'h0000300C, "t5_epc_keep");
    en = 1'b1; cp0_adr = 5'd14; cp0_wd = 32'h5000;
    push(K_EPC, "t5_epc_byp", 32'h5000);
    push(K_RD,  "t5_rd_byp",  32'h5000);
    drain();
    tick();
    en = 1'b0;
    rd(5'd14, 32'h5000, "t5_epc_wr");
    en = 1'b1; cp0_adr = 5'd15; cp0_wd = 32'h8000;
    push(K_EBASE, "t5_ebase_byp", 32'h8000);
    drain();
    tick();
    en = 1'b0;
    rd(5'd15, 32'h8000, "t5_ebase_wr");

    // Software interrupt: only IP[1:0] writable
    mtc0(5'd12, 32'h00000101);
    en = 1'b1; cp0_adr = 5'd13; cp0_wd = 32'hFFFFFFFF;
    push(K_REQ, "t4_req_pre", 32'd0);
    drain();
    tick();
    en = 1'b0;
    push(K_REQ, "t4_sw_req", 32'd1);
    drain();
    tick();
    rd(5'd13, 32'h00000300, "t4_cause");
    rd(5'd12, 32'h00000103, "t4_sr");
    mtc0(5'd12, 32'h0);
    mtc0(5'd13, 32'h0);
    rd(5'd13, 32'h0, "t4_cause_clr");

    // Timer: COUNT_DIV=4, Compare=10
    mtc0(5'd9, 32'd0);
    mtc0(5'd11, 32'd10);
    repeat (38) tick();
    rd(5'd9, 32'd9, "t3_cnt9");
    tick();
    rd(5'd9, 32'd10, "t3_cnt10");
    push(K_TI, "t3_ti_early", 32'd0);
    drain();
    tick();
    push(K_TI, "t3_ti_rise", 32'd1);
    drain();
    rd(5'd13, 32'h40008000, "t3_cause_ti");
    mtc0(5'd12, 32'h00008001);
    push(K_REQ, "t3_ti_req", 32'd1);
    drain();
    tick();
    mtc0(5'd12, 32'h0);
    mtc0(5'd11, 32'd20);
    push(K_TI, "t3_ti_clr", 32'd0);
    drain();
    mtc0(5'd9, 32'hFFFFFFFF);
    repeat (3) tick();
    rd(5'd9, 32'hFFFFFFFF, "t3_cnt_max");
    tick();
    rd(5'd9, 32'h0, "t3_cnt_wrap");

    // Reset while TI=1 and EXL=1
    mtc0(5'd9, 32'd5);
    mtc0(5'd11, 32'd5);
    tick();
    push(K_TI, "t6_ti_set", 32'd1);
    drain();
    mtc0(5'd12, 32'h2);
    rd(5'd12, 32'h2, "t6_sr_exl");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    push(K_TI, "t6_ti_rst", 32'd0);
    drain();
    rd(5'd12, 32'h0,        "t6_sr");
    rd(5'd13, 32'h0,        "t6_cause");
    rd(5'd14, 32'h0,        "t6_epc");
    rd(5'd15, 32'h4180,     "t6_ebase");
    rd(5'd11, 32'hFFFFFFFF, "t6_compare");
    rd(5'd9,  32'h0,        "t6_count");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
